// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, parity/framing/break detection
// and a show-ahead word FIFO with valid/ready handshake and sticky overrun.
module uart_rx_fifo #(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  input  logic                          rx_ready,
  input  logic                          overrun_clr,
  output logic                          rx_valid,
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int HALF_CNT     = CLKS_PER_BIT / 2 - 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;
  localparam int ENT_W        = PAYLOAD_BITS + 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic par_calc(input logic [PAYLOAD_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  logic                    sync1_q;
  logic                    sync2_q;
  logic [2:0]              hist_q;
  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              bit_idx_q;
  logic                    stop_idx_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    par_bit_q;
  logic                    frame_err_q;
  logic                    armed_q;

  logic                    vote_s;
  logic                    bit_end_s;
  logic                    last_stop_s;
  logic                    push_s;
  logic                    frame_fin_s;
  logic                    par_err_s;
  logic                    brk_s;
  logic [ENT_W-1:0]        push_word_s;

  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [LVL_W-1:0]        level_q;
  logic [LVL_W-1:0]        level_d;
  logic                    valid_q;
  logic [ENT_W-1:0]        head_q;
  logic [ENT_W-1:0]        head_d;
  logic                    overrun_q;
  logic                    overrun_d;
  logic                    pop_s;
  logic                    full_s;
  logic                    push_ok_s;
  logic                    drop_s;

  // Pin synchroniser and 3-sample vote history, idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  always_comb begin
    vote_s      = maj3(hist_q);
    bit_end_s   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    last_stop_s = (stop_idx_q == 1'(STOP_BITS - 1));
    push_s      = (state_q == S_STOP) && bit_end_s && last_stop_s;
    frame_fin_s = frame_err_q | ~vote_s;
    if (PARITY == 1) begin
      par_err_s = par_calc(shift_q, par_bit_q);
    end else if (PARITY == 2) begin
      par_err_s = ~par_calc(shift_q, par_bit_q);
    end else begin
      par_err_s = 1'b0;
    end
    brk_s       = frame_fin_s && (shift_q == {PAYLOAD_BITS{1'b0}}) &&
                  ((PARITY == 0) || !par_bit_q);
    push_word_s = {brk_s, frame_fin_s, par_err_s, shift_q};
  end

  // Frame FSM; armed_q blocks restart while a break keeps the line low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bit_idx_q   <= 4'd0;
      stop_idx_q  <= 1'b0;
      shift_q     <= {PAYLOAD_BITS{1'b0}};
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      if (push_s && frame_fin_s) begin
        armed_q <= 1'b0;
      end else if (sync2_q) begin
        armed_q <= 1'b1;
      end else begin
        armed_q <= armed_q;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          if (uart_rx_en && !sync2_q && armed_q) begin
            state_q <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          if (cnt_q == CNT_W'(HALF_CNT)) begin
            cnt_q <= {CNT_W{1'b0}};
            if (vote_s) begin
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_DATA;
              bit_idx_q   <= 4'd0;
              frame_err_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            cnt_q   <= {CNT_W{1'b0}};
            shift_q <= {vote_s, shift_q[PAYLOAD_BITS-1:1]};
            if (bit_idx_q == 4'(PAYLOAD_BITS - 1)) begin
              bit_idx_q  <= 4'd0;
              stop_idx_q <= 1'b0;
              state_q    <= (PARITY == 0) ? S_STOP : S_PARITY;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end_s) begin
            cnt_q     <= {CNT_W{1'b0}};
            par_bit_q <= vote_s;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end_s) begin
            cnt_q <= {CNT_W{1'b0}};
            if (!vote_s) begin
              frame_err_q <= 1'b1;
            end else begin
              frame_err_q <= frame_err_q;
            end
            if (last_stop_s) begin
              state_q <= S_IDLE;
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Next head register value mirrors what mem[rd_ptr] will hold after this edge.
  always_comb begin
    pop_s     = valid_q && rx_ready;
    full_s    = (level_q == LVL_W'(FIFO_DEPTH));
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;

    if (push_ok_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok_s && pop_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end

    if (level_d == {LVL_W{1'b0}}) begin
      head_d = {ENT_W{1'b0}};
    end else if (pop_s) begin
      if (level_q >= LVL_W'(2)) begin
        head_d = mem_q[rd_ptr_q + PTR_W'(1)];
      end else begin
        head_d = push_word_s;
      end
    end else if (level_q == {LVL_W{1'b0}}) begin
      head_d = push_word_s;
    end else begin
      head_d = head_q;
    end

    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      level_q   <= {LVL_W{1'b0}};
      valid_q   <= 1'b0;
      head_q    <= {ENT_W{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q   <= level_d;
      valid_q   <= (level_d != {LVL_W{1'b0}});
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_valid      = valid_q;
  assign rx_data       = head_q[PAYLOAD_BITS-1:0];
  assign rx_parity_err = head_q[PAYLOAD_BITS];
  assign rx_frame_err  = head_q[PAYLOAD_BITS+1];
  assign rx_break      = head_q[PAYLOAD_BITS+2];
  assign rx_overrun    = overrun_q;
  assign rx_level      = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: an 8N1 instance and an 8E2 instance at 16 clocks per bit.
module tb_uart_rx_fifo;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic rxd_a = 1'b1, ready_a = 1'b1, clr_a = 1'b0;
  logic rxd_b = 1'b1, ready_b = 1'b1, clr_b = 1'b0;

  logic       a_valid, a_perr, a_ferr, a_brk, a_ovr;
  logic [7:0] a_data;
  logic [2:0] a_level;
  logic       b_valid, b_perr, b_ferr, b_brk, b_ovr;
  logic [7:0] b_data;
  logic [2:0] b_level;

  int checks = 0;
  int errors = 0;
  int a_pops = 0, exp_pops_a = 0;
  int b_pops = 0, exp_pops_b = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;

  uart_rx_fifo #(.CLK_HZ(1_600_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .uart_rxd(rxd_a), .uart_rx_en(en),
    .rx_ready(ready_a), .overrun_clr(clr_a), .rx_valid(a_valid),
    .rx_data(a_data), .rx_parity_err(a_perr), .rx_frame_err(a_ferr),
    .rx_break(a_brk), .rx_overrun(a_ovr), .rx_level(a_level));

  uart_rx_fifo #(.CLK_HZ(1_600_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                 .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .uart_rxd(rxd_b), .uart_rx_en(en),
    .rx_ready(ready_b), .overrun_clr(clr_b), .rx_valid(b_valid),
    .rx_data(b_data), .rx_parity_err(b_perr), .rx_frame_err(b_ferr),
    .rx_break(b_brk), .rx_overrun(b_ovr), .rx_level(b_level));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard whenever a word is handed over.
  always @(negedge clk) begin
    if (!reset && a_valid && ready_a) begin
      a_pops++;
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_a: unexpected word %0h, expected none", a_data);
      end else begin
        ea = exp_a.pop_front();
        check("word_a", {a_data, a_perr, a_ferr, a_brk}, ea);
      end
    end
    if (!reset && b_valid && ready_b) begin
      b_pops++;
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_b: unexpected word %0h, expected none", b_data);
      end else begin
        eb = exp_b.pop_front();
        check("word_b", {b_data, b_perr, b_ferr, b_brk}, eb);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit to_b, input logic [11:0] frame, input int nbits,
                      input int glitch_bit);
    logic v;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk);
        #1;
        v = frame[i];
        if (i == glitch_bit && c == 8) v = ~v;
        if (to_b) rxd_b = v;
        else rxd_a = v;
      end
    end
  endtask

  function automatic logic [11:0] fr_a(input logic [7:0] d);
    return {3'b000, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [11:0] fr_b(input logic [7:0] d, input logic par);
    return {2'b11, par, d, 1'b0};
  endfunction

  task automatic expect_a(input logic [7:0] d, input logic p, input logic f, input logic b);
    exp_a.push_back({d, p, f, b});
    exp_pops_a++;
  endtask

  task automatic expect_b(input logic [7:0] d, input logic p, input logic f, input logic b);
    exp_b.push_back({d, p, f, b});
    exp_pops_b++;
  endtask

  initial begin
    tick(5);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data", a_data, 8'h00);
    check("rst_level", a_level, 3'd0);
    check("rst_overrun", a_ovr, 1'b0);

    // 8N1 basic word
    expect_a(8'hA5, 1'b0, 1'b0, 1'b0);
    send(1'b0, fr_a(8'hA5), 10, -1);
    tick(10);
    check("a5_pops", a_pops, exp_pops_a);
    check("a5_level", a_level, 3'd0);

    // Even parity, two stop bits: good and bad parity bit
    expect_b(8'h37, 1'b0, 1'b0, 1'b0);
    send(1'b1, fr_b(8'h37, 1'b1), 12, -1);
    expect_b(8'h37, 1'b1, 1'b0, 1'b0);
    send(1'b1, fr_b(8'h37, 1'b0), 12, -1);
    tick(10);
    check("par_pops", b_pops, exp_pops_b);
    check("par_level", b_level, 3'd0);

    // False start: 4-clock low pulse
    rxd_a = 1'b0;
    tick(4);
    rxd_a = 1'b1;
    tick(40);
    check("glitch_level", a_level, 3'd0);
    check("glitch_pops", a_pops, exp_pops_a);

    // 1-clock glitch at a data-bit centre of 0x00
    expect_a(8'h00, 1'b0, 1'b0, 1'b0);
    send(1'b0, fr_a(8'h00), 10, 4);
    tick(10);
    check("vote_pops", a_pops, exp_pops_a);

    // Break: 20 bit times low gives exactly one word
    expect_a(8'h00, 1'b0, 1'b1, 1'b1);
    rxd_a = 1'b0;
    tick(320);
    rxd_a = 1'b1;
    tick(60);
    check("break_pops", a_pops, exp_pops_a);
    check("break_level", a_level, 3'd0);

    // Overrun: five words into a depth-4 FIFO with no consumer
    ready_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_a(8'(k), 1'b0, 1'b0, 1'b0);
      send(1'b0, fr_a(8'(k)), 10, -1);
    end
    tick(10);
    @(negedge clk);
    check("ovr_level", a_level, 3'd4);
    check("ovr_flag", a_ovr, 1'b1);
    check("ovr_head_valid", a_valid, 1'b1);
    check("ovr_head_data", a_data, 8'h01);
    tick(1);
    ready_a = 1'b1;
    tick(10);
    check("drain_pops", a_pops, exp_pops_a);
    check("drain_level", a_level, 3'd0);
    check("ovr_sticky", a_ovr, 1'b1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    @(negedge clk);
    check("ovr_clear", a_ovr, 1'b0);

    // Reset in the middle of DATA with a word waiting
    tick(1);
    ready_a = 1'b0;
    send(1'b0, fr_a(8'h33), 10, -1);
    tick(5);
    check("pre_rst_valid", a_valid, 1'b1);
    send(1'b0, 12'b0000_0000_1010, 4, -1);
    tick(1);
    reset = 1'b1;
    rxd_a = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", a_valid, 1'b0);
    check("midrst_data", a_data, 8'h00);
    check("midrst_level", a_level, 3'd0);
    tick(1);
    ready_a = 1'b1;
    tick(20);
    expect_a(8'h5A, 1'b0, 1'b0, 1'b0);
    send(1'b0, fr_a(8'h5A), 10, -1);
    tick(20);
    check("final_pops_a", a_pops, exp_pops_a);
    check("final_queue_a", exp_a.size(), 0);
    check("final_queue_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: the successor to the current 8N1 receiver, sitting between the `uart_rxd` pin and the command parser that drives the PWM channels. It adds configurable payload width, parity and stop bits, 3-sample majority voting, and false-start rejection. It reports parity, framing and break errors per word and buffers received words in a show-ahead FIFO with a valid/ready handshake and sticky overrun.

## Interface
- `CLK_HZ`, 27_000_000, system clock frequency in Hz
- `BIT_RATE`, 9600, line rate in bit/s; `CLKS_PER_BIT = CLK_HZ / BIT_RATE` (integer division), must be ≥ 8
- `PAYLOAD_BITS`, 8, data bits per frame, legal 5..9
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, legal 1 or 2
- `FIFO_DEPTH`, 4, word buffer depth, power of two ≥ 2
- `clk  in  1`  system clock, all logic on the rising edge
- `reset  in  1`  synchronous, active-high reset
- `uart_rxd  in  1`  asynchronous serial input, idle high
- `uart_rx_en  in  1`  receive enable
- `rx_ready  in  1`  consumer accepts the head word
- `overrun_clr  in  1`  one-cycle pulse that clears `rx_overrun`
- `rx_valid  out  1`  FIFO non-empty; head word presented
- `rx_data  out  PAYLOAD_BITS`  head word data, LSB = first bit received
- `rx_parity_err  out  1`  head word parity mismatch (always 0 when `PARITY`=0)
- `rx_frame_err  out  1`  head word had a stop bit sampled low
- `rx_break  out  1`  head word is a break: frame error, all data bits 0, parity bit (if present) 0
- `rx_overrun  out  1`  sticky: a word was dropped because the FIFO was full
- `rx_level  out  $clog2(FIFO_DEPTH)+1`  current FIFO occupancy

## Operation
- Input conditioning: two-flop synchroniser on `uart_rxd`, both flops reset to 1. A 3-bit history register holds the last three synchronised samples, reset value 3'b111. The vote output is the majority of those three bits.
- The cycle counter `cnt` runs 0..CLKS_PER_BIT-1 while not in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `cnt`=0. Enter START when `uart_rx_en`=1 and the synchronised line is 0. `uart_rx_en` is examined only in IDLE; deasserting it mid-frame does not abort the frame.
- START: at `cnt`=CLKS_PER_BIT/2-1 (start-bit centre), evaluate the vote.
  - Vote = 1: false start; return to IDLE with no push.
  - Vote = 0: clear `cnt` and enter DATA.
- DATA, PARITY, STOP: each bit completes at `cnt`=CLKS_PER_BIT-1, which is the next bit centre. The vote is taken at that cycle and `cnt` clears.
  - Data bits are shifted in LSB first, PAYLOAD_BITS of them.
  - PARITY is skipped when `PARITY`=0.
  - STOP takes STOP_BITS votes; any vote of 0 sets the frame error.
- Parity check: even mode requires the XOR of data and parity bit to be 0; odd mode requires it to be 1.
- After the last stop vote, push {break, frame_err, parity_err, data} in that same cycle and go straight to IDLE. A start edge is then accepted from the next cycle, which resynchronises mid-stop.
- FIFO:
  - Show-ahead; all `rx_*` head outputs come from the head entry.
  - A pop occurs when `rx_valid` and `rx_ready` are both 1.
  - Push while full without a pop in the same cycle: the word is dropped, the FIFO is unchanged, and `rx_overrun` is set.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overrun.
  - Push and pop in the same cycle while empty: the push lands; `rx_valid` rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- `rx_overrun`: set and clear in the same cycle → set wins.
- Reset, including mid-frame: FSM → IDLE, counters 0, FIFO emptied, synchroniser/history → 1. All outputs read 0 (`rx_data`=0, `rx_level`=0, `rx_overrun`=0).

## Timing
- Pin to synchronised line: 2 cycles. History register: +1 cycle.
- A valid start edge enters START 3 cycles after the pin falls.
- Push occurs at the centre of the last stop bit. `rx_valid` and head outputs update on the following cycle (1-cycle latency).
- A pop updates `rx_valid` and head outputs on the next cycle. `rx_level` is registered and updates with the same 1-cycle latency as `rx_valid`.
- Minimum frame-to-frame spacing: the start edge may arrive any cycle after the push.
- Sampling tolerance follows from centre sampling with ±1-cycle voting: about ±4% baud mismatch at CLKS_PER_BIT ≥ 16.

## Test plan
All scenarios use CLK_HZ=1_600_000, BIT_RATE=100_000 (16 clocks per bit).
- 8N1, send 0xA5, `rx_ready`=1 → single `rx_valid` pulse with `rx_data`=0xA5, all error flags 0, `rx_level` returns to 0.
- PARITY=1, STOP_BITS=2:
  - send 0x37 with correct parity bit 1 → `rx_parity_err`=0;
  - resend with parity bit 0 → `rx_parity_err`=1, data 0x37.
- Glitch: line low for 4 clocks, then high → no push, FSM back in IDLE, `rx_level`=0. Then a 1-clock glitch inside a data-bit centre of 0x00 → received as 0x00 (vote masks it).
- Break: line held low for 20 bit times → one word with `rx_data`=0, `rx_frame_err`=1, `rx_break`=1. No further word until the line returns high and falls again.
- FIFO_DEPTH=4, `rx_ready`=0, send 0x01..0x05 → `rx_level`=4 and `rx_overrun`=1. Then drain → reads 0x01..0x04 in order. Pulse `overrun_clr` → `rx_overrun`=0.
- Assert `reset` in the middle of DATA → outputs read 0 the next cycle. The next full frame 0x5A is received correctly.
